// File: rtl/lif_pe_pkg.sv
// rtl/lif_pe_pkg.sv - shared types, Q-format constants and saturation helper for lif_pe
package lif_pe_pkg;

  typedef enum logic {
    ST_ACTIVE     = 1'b0,
    ST_REFRACTORY = 1'b1
  } lif_state_e;

  localparam int Q_DATA_W = 16;
  localparam int Q_FRAC_W = 8;
  localparam int SAT_W    = 64;

  // Clamp a wide signed value into the signed range of a w-bit word; caller truncates.
  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] x,
                                                     input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/lif_pe_adder_tree.sv
// rtl/lif_pe_adder_tree.sv - combinational signed sum of polarity-selected channel weights
module lif_pe_adder_tree #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16
) (
  input  logic [N_CH-1:0]                       spike,
  input  logic [N_CH-1:0]                       polarity,
  input  logic [N_CH*DATA_W-1:0]                weight,
  output logic signed [DATA_W+$clog2(N_CH):0]   sum
);

  localparam int SUM_W = DATA_W + $clog2(N_CH) + 1;

  logic signed [SUM_W-1:0] acc;
  logic signed [SUM_W-1:0] w_ext;

  // Accumulator is wide enough for N_CH full-scale weights of either sign.
  always_comb begin
    acc   = '0;
    w_ext = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_ext = SUM_W'(signed'(weight[i*DATA_W +: DATA_W]));
      if (spike[i]) begin
        acc = polarity[i] ? (acc + w_ext) : (acc - w_ext);
      end
    end
    sum = acc;
  end

endmodule

// File: rtl/lif_pe.sv
// rtl/lif_pe.sv - leaky integrate-and-fire neuron with refractory period
// Leak term is built only when LIF_PE_LEAK_EN is defined.
module lif_pe
  import lif_pe_pkg::*;
#(
  parameter int DATA_W   = Q_DATA_W,
  parameter int FRAC_W   = Q_FRAC_W,
  parameter int N_CH     = 4,
  parameter int REFRAC_W = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  input  logic [N_CH-1:0]            in_spike,
  input  logic [N_CH-1:0]            in_polarity,
  input  logic [N_CH*DATA_W-1:0]     in_weight,
  input  logic signed [DATA_W-1:0]   threshold,
  input  logic [3:0]                 leak_shift,
  input  logic [REFRAC_W-1:0]        refrac_len,
  input  logic                       reset_mode,
  output logic                       out_spike,
  output logic signed [DATA_W-1:0]   membrane,
  output logic                       refractory
);

  localparam int SUM_W         = DATA_W + $clog2(N_CH) + 1;
  localparam int unused_frac_w = FRAC_W;

  lif_state_e               state;
  logic [REFRAC_W-1:0]      refrac_cnt;
  logic signed [SUM_W-1:0]  sum;
  logic signed [DATA_W-1:0] leak;
  logic signed [DATA_W-1:0] v_next;
  logic signed [DATA_W-1:0] v_reset;
  logic signed [SAT_W-1:0]  raw_w;
  logic signed [SAT_W-1:0]  diff_w;
  logic                     fire;

  lif_pe_adder_tree #(
    .N_CH  (N_CH),
    .DATA_W(DATA_W)
  ) u_adder_tree (
    .spike   (in_spike),
    .polarity(in_polarity),
    .weight  (in_weight),
    .sum     (sum)
  );

`ifdef LIF_PE_LEAK_EN
  assign leak = membrane >>> leak_shift;
`else
  logic unused_leak_shift;
  assign unused_leak_shift = ^leak_shift;
  assign leak = '0;
`endif

  // All arithmetic is done wide and clamped once, so nothing can wrap on the way.
  always_comb begin
    raw_w   = SAT_W'(membrane) - SAT_W'(leak) + SAT_W'(sum);
    v_next  = DATA_W'(sat_to(raw_w, DATA_W));
    diff_w  = SAT_W'(v_next) - SAT_W'(threshold);
    v_reset = reset_mode ? DATA_W'(sat_to(diff_w, DATA_W)) : '0;
    fire    = (state == ST_ACTIVE) && in_valid && (v_next >= threshold);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_ACTIVE;
      refrac_cnt <= '0;
      membrane   <= '0;
      out_spike  <= 1'b0;
    end else begin
      out_spike <= fire;
      case (state)
        ST_ACTIVE: begin
          if (in_valid) begin
            if (fire) begin
              membrane <= v_reset;
              if (refrac_len != '0) begin
                state      <= ST_REFRACTORY;
                refrac_cnt <= refrac_len;
              end
            end else begin
              membrane <= v_next;
            end
          end
        end
        ST_REFRACTORY: begin
          if (refrac_cnt <= REFRAC_W'(1)) begin
            state      <= ST_ACTIVE;
            refrac_cnt <= '0;
          end else begin
            refrac_cnt <= refrac_cnt - REFRAC_W'(1);
          end
        end
        default: state <= ST_ACTIVE;
      endcase
    end
  end

  assign refractory = (state == ST_REFRACTORY);

endmodule

// File: tb/tb_lif_pe.sv
// tb/tb_lif_pe.sv - scoreboard bench for lif_pe (Q8.8, 4 channels)
module tb_lif_pe;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [3:0]  in_spike;
  logic [3:0]  in_polarity;
  logic [63:0] in_weight;
  logic [15:0] threshold;
  logic [3:0]  leak_shift;
  logic [3:0]  refrac_len;
  logic        reset_mode;
  logic        out_spike;
  logic [15:0] membrane;
  logic        refractory;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] mem;
    logic        spk;
    logic        refr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  lif_pe #(
    .DATA_W  (16),
    .FRAC_W  (8),
    .N_CH    (4),
    .REFRAC_W(4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_spike   (in_spike),
    .in_polarity(in_polarity),
    .in_weight  (in_weight),
    .threshold  (threshold),
    .leak_shift (leak_shift),
    .refrac_len (refrac_len),
    .reset_mode (reset_mode),
    .out_spike  (out_spike),
    .membrane   (membrane),
    .refractory (refractory)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] w0_only(input logic [15:0] x);
    return {48'h0, x};
  endfunction

  // Drive one sample in the low phase and queue what must appear after the next rising edge.
  task automatic step(input string tag, input logic v, input logic [3:0] spk,
                      input logic [3:0] pol, input logic [63:0] w,
                      input logic [15:0] em, input logic es, input logic er);
    @(negedge clk);
    in_valid    = v;
    in_spike    = spk;
    in_polarity = pol;
    in_weight   = w;
    sb.push_back(exp_t'{tag: tag, mem: em, spk: es, refr: er});
  endtask

  task automatic flush();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_spike = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rstn     = 1'b0;
    #2;
    rstn     = 1'b1;
  endtask

  always @(posedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      #1;
      check_val({mon_e.tag, "_mem"}, 32'(membrane), 32'(mon_e.mem));
      check_val({mon_e.tag, "_spk"}, 32'(out_spike), 32'(mon_e.spk));
      check_val({mon_e.tag, "_ref"}, 32'(refractory), 32'(mon_e.refr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b0;
    in_valid    = 1'b0;
    in_spike    = '0;
    in_polarity = '0;
    in_weight   = '0;
    threshold   = 16'h0200;
    leak_shift  = 4'd0;
    refrac_len  = 4'd0;
    reset_mode  = 1'b0;
    #12;
    check_val("rst_mem", 32'(membrane), 32'h0);
    check_val("rst_spk", 32'(out_spike), 32'h0);
    check_val("rst_ref", 32'(refractory), 32'h0);
    rstn = 1'b1;

    // Basic integrate and fire, refrac_len=0
    step("int1",  1'b1, 4'b0001, 4'b0001, w0_only(16'h0100), 16'h0100, 1'b0, 1'b0);
    step("fire1", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0100), 16'h0000, 1'b1, 1'b0);
    step("pulse", 1'b0, 4'b0000, 4'b0000, w0_only(16'h0000), 16'h0000, 1'b0, 1'b0);
    step("back1", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0200), 16'h0000, 1'b1, 1'b0);
    step("back2", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0200), 16'h0000, 1'b1, 1'b0);
    step("int2",  1'b1, 4'b0001, 4'b0001, w0_only(16'h0100), 16'h0100, 1'b0, 1'b0);
    step("hold",  1'b0, 4'b0001, 4'b0001, w0_only(16'h0100), 16'h0100, 1'b0, 1'b0);
    step("neg",   1'b1, 4'b0010, 4'b0000, {16'h0, 16'h0, 16'h0080, 16'h0}, 16'h0080, 1'b0, 1'b0);
    step("mix",   1'b1, 4'b0101, 4'b0001, {16'h7000, 16'h0010, 16'h0, 16'h0040},
         16'h00B0, 1'b0, 1'b0);
    flush();

    // Subtract-threshold reset
    do_reset();
    reset_mode = 1'b1;
    step("rm_int",  1'b1, 4'b0001, 4'b0001, w0_only(16'h0180), 16'h0180, 1'b0, 1'b0);
    step("rm_fire", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0100), 16'h0080, 1'b1, 1'b0);
    flush();

    // Saturation in both directions
    do_reset();
    reset_mode = 1'b0;
    threshold  = 16'h7FFF;
    step("sat_hi", 1'b1, 4'b1111, 4'b1111, {4{16'h7FFF}}, 16'h0000, 1'b1, 1'b0);
    flush();
    threshold = 16'h0200;
    step("pre_lo", 1'b1, 4'b0001, 4'b0000, w0_only(16'h7F00), 16'h8100, 1'b0, 1'b0);
    step("sat_lo", 1'b1, 4'b1111, 4'b0000, {4{16'h7FFF}}, 16'h8000, 1'b0, 1'b0);
    step("sat_lo2", 1'b1, 4'b1111, 4'b0000, {4{16'h7FFF}}, 16'h8000, 1'b0, 1'b0);
    flush();

    // Refractory period of 3 cycles; config changes inside it must not matter
    do_reset();
    refrac_len = 4'd3;
    step("rf_fire", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0200), 16'h0000, 1'b1, 1'b1);
    flush();
    threshold  = 16'h0001;
    refrac_len = 4'd7;
    step("rf_c2", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0300), 16'h0000, 1'b0, 1'b1);
    step("rf_c3", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0300), 16'h0000, 1'b0, 1'b1);
    step("rf_end", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0300), 16'h0000, 1'b0, 1'b0);
    flush();
    threshold  = 16'h0200;
    refrac_len = 4'd0;
    step("rf_after", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0100), 16'h0100, 1'b0, 1'b0);
    flush();

    // Leak (ignored when the leak build option is off)
    do_reset();
    threshold = 16'h7FFF;
    step("lk_load", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0400), 16'h0400, 1'b0, 1'b0);
    flush();
    leak_shift = 4'd2;
`ifdef LIF_PE_LEAK_EN
    step("lk_apply", 1'b1, 4'b0000, 4'b0000, w0_only(16'h0000), 16'h0300, 1'b0, 1'b0);
    step("lk_hold",  1'b0, 4'b0000, 4'b0000, w0_only(16'h0000), 16'h0300, 1'b0, 1'b0);
`else
    step("lk_apply", 1'b1, 4'b0000, 4'b0000, w0_only(16'h0000), 16'h0400, 1'b0, 1'b0);
    step("lk_hold",  1'b0, 4'b0000, 4'b0000, w0_only(16'h0000), 16'h0400, 1'b0, 1'b0);
`endif
    flush();
    leak_shift = 4'd0;
    threshold  = 16'h0200;

    // Asynchronous reset during refractory cycle 2
    do_reset();
    reset_mode = 1'b1;
    refrac_len = 4'd3;
    step("ar_int",  1'b1, 4'b0001, 4'b0001, w0_only(16'h0100), 16'h0100, 1'b0, 1'b0);
    step("ar_fire", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0180), 16'h0080, 1'b1, 1'b1);
    step("ar_c2",   1'b1, 4'b0001, 4'b0001, w0_only(16'h0100), 16'h0080, 1'b0, 1'b1);
    flush();
    rstn = 1'b0;
    #1;
    check_val("ar_mem", 32'(membrane), 32'h0);
    check_val("ar_spk", 32'(out_spike), 32'h0);
    check_val("ar_ref", 32'(refractory), 32'h0);
    #1;
    rstn       = 1'b1;
    reset_mode = 1'b0;
    step("ar_next", 1'b1, 4'b0001, 4'b0001, w0_only(16'h0100), 16'h0100, 1'b0, 1'b0);
    flush();

    #1;
    check_val("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
